// File: rtl/dsi_tx_pkg.sv
// Shared definitions for the DSI TX stages: data-type codes, scheduler states and
// the packet-header word layout.
package dsi_tx_pkg;

  localparam logic [5:0] DT_VSS    = 6'h01;
  localparam logic [5:0] DT_HSS    = 6'h21;
  localparam logic [5:0] DT_RGB888 = 6'h3E;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SYNC      = 3'd1,
    ST_WAIT_LINE = 3'd2,
    ST_HDR       = 3'd3,
    ST_DATA      = 3'd4,
    ST_FEND      = 3'd5
  } sched_state_e;

  // The top byte is left zero as the slot the ECC stage fills in.
  function automatic logic [31:0] build_hdr(input logic [7:0] di, input logic [15:0] wc);
    return {8'h00, wc[15:8], wc[7:0], di};
  endfunction

endpackage

// File: rtl/dsi_tx_out_reg.sv
// Single-entry valid/ready output register with sop/eop sidebands. Accepts a new
// word whenever it is empty or its current word is being taken downstream.
module dsi_tx_out_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic        sop_i,
  input  logic        eop_i,
  input  logic        ready_i,
  output logic        can_load_o,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        sop_o,
  output logic        eop_o
);

  logic [31:0] data_q;
  logic        valid_q;
  logic        sop_q;
  logic        eop_q;

  assign can_load_o = !valid_q || ready_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else if (can_load_o) begin
      valid_q <= load_i;
      if (load_i) begin
        data_q <= data_i;
        sop_q  <= sop_i;
        eop_q  <= eop_i;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;

endmodule

// File: rtl/dsi_tx_line_scheduler.sv
// Drains the pixel buffer one line at a time into a DSI video-mode packet stream:
// VSS/HSS short packet, RGB888 long-packet header, then one line of payload words.
module dsi_tx_line_scheduler
  import dsi_tx_pkg::*;
#(
  parameter int         LINE_BYTES      = 640,
  parameter int         LINES_PER_FRAME = 480,
  parameter logic [1:0] VC              = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] fifo_data,
  input  logic        fifo_not_empty,
  input  logic        fifo_line_ready,
  output logic        fifo_read_ack,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  input  logic        out_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
);

  localparam int          LINE_WORDS = LINE_BYTES / 4;
  localparam int          WW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int          LNW        = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam logic [15:0] WC         = 16'(LINE_BYTES);
  localparam logic [WW-1:0]  LAST_WORD = WW'(LINE_WORDS - 1);
  localparam logic [LNW-1:0] LAST_LINE = LNW'(LINES_PER_FRAME - 1);

  sched_state_e   state_q;
  logic [LNW-1:0] line_q;
  logic [WW-1:0]  word_q;
  logic           busy_q;
  logic           frame_done_q;
  logic           underflow_q;
  logic           empty_run_q;

  logic        can_load;
  logic        ld;
  logic [31:0] ld_data;
  logic        ld_sop;
  logic        ld_eop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ld            = 1'b0;
    ld_data       = '0;
    ld_sop        = 1'b0;
    ld_eop        = 1'b0;
    fifo_read_ack = 1'b0;
    case (state_q)
      ST_SYNC: begin
        ld      = can_load;
        ld_data = build_hdr({VC, (line_q == '0) ? DT_VSS : DT_HSS}, 16'h0000);
        ld_sop  = 1'b1;
        ld_eop  = 1'b1;
      end
      ST_HDR: begin
        ld      = can_load;
        ld_data = build_hdr({VC, DT_RGB888}, WC);
        ld_sop  = 1'b1;
      end
      ST_DATA: begin
        fifo_read_ack = fifo_not_empty && can_load;
        ld            = fifo_read_ack;
        ld_data       = fifo_data;
        ld_eop        = (word_q == LAST_WORD);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      word_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
      empty_run_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // Flag only the first cycle of each run of an empty buffer mid-line.
      underflow_q  <= (state_q == ST_DATA) && !fifo_not_empty && !empty_run_q;
      empty_run_q  <= (state_q == ST_DATA) && !fifo_not_empty;
      case (state_q)
        ST_IDLE: if (enable) begin
          state_q <= ST_SYNC;
          line_q  <= '0;
          busy_q  <= 1'b1;
        end
        ST_SYNC: if (can_load) state_q <= ST_WAIT_LINE;
        ST_WAIT_LINE: if (fifo_line_ready && can_load) state_q <= ST_HDR;
        ST_HDR: if (can_load) begin
          state_q <= ST_DATA;
          word_q  <= '0;
        end
        ST_DATA: if (fifo_read_ack) begin
          if (word_q == LAST_WORD) begin
            word_q <= '0;
            if (line_q == LAST_LINE) begin
              state_q <= ST_FEND;
            end else begin
              line_q  <= line_q + 1'b1;
              state_q <= ST_SYNC;
            end
          end else begin
            word_q <= word_q + 1'b1;
          end
        end
        ST_FEND: if (can_load) begin
          frame_done_q <= 1'b1;
          line_q       <= '0;
          if (enable) begin
            state_q <= ST_SYNC;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dsi_tx_out_reg u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ld),
    .data_i     (ld_data),
    .sop_i      (ld_sop),
    .eop_i      (ld_eop),
    .ready_i    (out_ready),
    .can_load_o (can_load),
    .data_o     (out_data),
    .valid_o    (out_valid),
    .sop_o      (out_sop),
    .eop_o      (out_eop)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underflow  = underflow_q;

endmodule
